fetch_redirect_ctrl: RTL and testbench
======================================

// Module: fetch_redirect_ctrl
// PURPOSE
//  Next-PC sequencer for the dual-issue fetch stage. Each fetch is one aligned 2-instruction pair.
//  Arbitrates the PC redirect sources: exception, taken branch/jump, and a JR whose target is still pending.
//  Drives the instruction-memory request handshake, and emits squash pulses to the IF/ID register for delay-slot handling.
//  Sits between ID/EX (redirect sources) and the IF stage / instruction SRAM port.
// PARAMETERS
//  RESET_PC    32'hBFC0_0000  fetch address after reset
//  FETCH_BYTES 8              PC increment per accepted fetch (2 instructions)
// PORTS
//  clk          in   1   clock, rising edge
//  reset        in   1   asynchronous, active-low
//  stall        in   1   pipeline hold from ID/hazard unit
//  exc_req      in   1   exception/interrupt redirect, 1-cycle pulse
//  exc_pc       in   32  exception vector
//  br_req       in   1   taken branch/jump/jr resolved in ID, 1-cycle pulse
//  br_lane      in   1   0 = branch in lane 0 of ID pair; 1 = branch in lane 1
//  br_target    in   32  target (valid with br_req when br_is_jr=0)
//  br_is_jr     in   1   target comes from register; may not be ready
//  jr_data_ok   in   1   jr_data valid
//  jr_data      in   32  register target for JR/JALR
//  fetch_req    out  1   instruction-memory request valid
//  fetch_addr   out  32  request address (= current pc)
//  fetch_ready  in   1   memory accepts request this cycle
//  flush_if     out  1   1-cycle: discard both instructions of the pair now in IF
//  kill_hi      out  1   1-cycle: discard lane 1 only of the pair now in IF
//  addr_err     out  1   1-cycle: redirect target has addr[1:0]!=0 (drives IADEE)
//  state_o      out  2   FSM state for debug
// BEHAVIOUR
//  Reset (async, reset==0):
//   - pc=RESET_PC, state=RUN, fetch_req=0.
//   - flush_if=kill_hi=addr_err=0; pending and jr_lane regs cleared.
//   - fetch_req rises on the first clk edge after reset deasserts.
//  States:
//   - RUN    : normal fetch.
//   - PEND   : branch arrived during stall; held in pend_target/pend_lane.
//   - JRWAIT : JR target not yet available.
//  Advance: in RUN with fetch_req&fetch_ready&!stall -> pc<=pc+FETCH_BYTES (32-bit wrap, no saturation).
//  Handshake:
//   - fetch_addr is stable while fetch_req=1 and fetch_ready=0.
//   - Only a redirect may change fetch_addr before acceptance; the old request is then abandoned.
//  Priority, highest first: reset > exc_req > branch/jr > stall > advance.
//  exc_req (any state, stall ignored):
//   - next edge: pc<=exc_pc, state<=RUN, flush_if=1, pending cleared.
//   - A simultaneous br_req is dropped.
//  br_req in RUN, stall=0, target known (br_is_jr=0, or br_is_jr=1 with jr_data_ok=1, target=jr_data):
//   - next edge: pc<=target.
//   - br_lane=0: the delay slot is lane 1 of the ID pair, so the IF pair is wrong-path -> flush_if=1.
//   - br_lane=1: the delay slot is lane 0 of the IF pair -> kill_hi=1 (lane 0 kept).
//   - Latency: new fetch_addr visible exactly 1 cycle after br_req.
//  br_req with stall=1:
//   - latch target/lane/is_jr, state<=PEND, no pc change.
//   - On the first cycle with stall=0, apply as above.
//   - The squash pulse coincides with that cycle's edge.
//  br_req with br_is_jr=1 and jr_data_ok=0:
//   - state<=JRWAIT, latch lane, fetch_req=0, pc held.
//   - In JRWAIT, the first cycle with jr_data_ok=1 applies the redirect with target=jr_data and the latched lane; state<=RUN.
//   - exc_req in JRWAIT or PEND aborts the wait.
//  br_req while already in PEND/JRWAIT: ignored (ID guarantees one outstanding branch).
//  addr_err: pulses with any redirect whose target[1:0]!=0. The redirect is still taken; the exception unit follows up.
//  flush_if and kill_hi are never asserted together; flush_if wins.
// TESTING
//  1. Reset release, fetch_ready=1 -> fetch_addr BFC00000, BFC00008, BFC00010 on consecutive cycles.
//  2. br_req lane0, target 0xBFC00100 -> next cycle fetch_addr=BFC00100, flush_if=1 for 1 cycle, kill_hi=0.
//  3. br_req lane1, target 0xBFC00200 -> kill_hi=1 for 1 cycle, fetch_addr=BFC00200 next cycle.
//  4. br_is_jr=1, jr_data_ok low 3 cycles then jr_data=0x80001000 -> fetch_req=0 for 3 cycles, then fetch_addr=80001000.
//  5. br_req with stall=1 for 2 cycles -> pc held, state PEND; redirect 1 cycle after stall drops.
//  6. exc_req with br_req same cycle, exc_pc=0xBFC00380 -> fetch_addr=BFC00380, branch dropped; target 0x...02 -> addr_err=1.

Source files
------------

// File: rtl/fetch_redirect_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_redirect_ctrl
//  Purpose  : Next-PC sequencer for the dual-issue fetch stage. Each fetch is
//             one aligned 2-instruction pair. Arbitrates PC redirects
//             (exception, resolved branch/jump, JR with pending target),
//             drives the instruction-memory request handshake and produces
//             squash pulses for the IF/ID register (delay-slot handling).
//  Ports    : clk, reset (async, active-low)
//             stall                       - pipeline hold from ID/hazard unit
//             exc_req/exc_pc              - exception redirect pulse + vector
//             br_req/br_lane/br_target    - taken branch resolved in ID
//             br_is_jr/jr_data_ok/jr_data - register-target jump and its data
//             fetch_req/fetch_addr        - memory request (addr = pc)
//             fetch_ready                 - memory accepts request
//             flush_if/kill_hi            - squash whole IF pair / lane 1 only
//             addr_err                    - misaligned redirect target
//             state_o                     - FSM state (debug)
//  Revision : 1.0 - initial release
// ============================================================================
module fetch_redirect_ctrl #(
    parameter logic [31:0] RESET_PC    = 32'hBFC0_0000,
    parameter int unsigned FETCH_BYTES = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        exc_req,
    input  logic [31:0] exc_pc,
    input  logic        br_req,
    input  logic        br_lane,
    input  logic [31:0] br_target,
    input  logic        br_is_jr,
    input  logic        jr_data_ok,
    input  logic [31:0] jr_data,
    output logic        fetch_req,
    output logic [31:0] fetch_addr,
    input  logic        fetch_ready,
    output logic        flush_if,
    output logic        kill_hi,
    output logic        addr_err,
    output logic [1:0]  state_o
);

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_PEND   = 2'd1,
        ST_JRWAIT = 2'd2
    } state_t;

    localparam logic [31:0] C_FETCH_INC = 32'(FETCH_BYTES);

    state_t      r_state, w_state_nxt;
    logic [31:0] r_pc, w_pc_nxt;
    logic [31:0] r_pend_target, w_pend_target_nxt;
    logic        r_pend_lane, w_pend_lane_nxt;
    logic        r_pend_is_jr, w_pend_is_jr_nxt;
    logic        r_started;
    logic        r_flush, w_flush_nxt;
    logic        r_kill, w_kill_nxt;
    logic        r_aerr, w_aerr_nxt;

    // Redirect request assembled by the state logic, applied in one place.
    logic        w_redir;
    logic [31:0] w_redir_target;
    logic        w_redir_lane;

    // No request until the first edge after reset; none while the JR target
    // is unknown since there is nothing valid to fetch.
    assign fetch_req  = r_started && (r_state != ST_JRWAIT);
    assign fetch_addr = r_pc;
    assign flush_if   = r_flush;
    assign kill_hi    = r_kill;
    assign addr_err   = r_aerr;
    assign state_o    = r_state;

    always_comb begin
        w_state_nxt       = r_state;
        w_pc_nxt          = r_pc;
        w_pend_target_nxt = r_pend_target;
        w_pend_lane_nxt   = r_pend_lane;
        w_pend_is_jr_nxt  = r_pend_is_jr;
        w_flush_nxt       = 1'b0;
        w_kill_nxt        = 1'b0;
        w_aerr_nxt        = 1'b0;
        w_redir           = 1'b0;
        w_redir_target    = br_target;
        w_redir_lane      = br_lane;

        if (exc_req) begin
            // Exception overrides everything, including a same-cycle branch.
            w_state_nxt       = ST_RUN;
            w_pc_nxt          = exc_pc;
            w_flush_nxt       = 1'b1;
            w_aerr_nxt        = |exc_pc[1:0];
            w_pend_target_nxt = 32'd0;
            w_pend_lane_nxt   = 1'b0;
            w_pend_is_jr_nxt  = 1'b0;
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (br_req) begin
                        if (stall) begin
                            w_state_nxt       = ST_PEND;
                            w_pend_target_nxt = br_target;
                            w_pend_lane_nxt   = br_lane;
                            w_pend_is_jr_nxt  = br_is_jr;
                        end else if (br_is_jr && !jr_data_ok) begin
                            w_state_nxt      = ST_JRWAIT;
                            w_pend_lane_nxt  = br_lane;
                            w_pend_is_jr_nxt = 1'b1;
                        end else begin
                            w_redir        = 1'b1;
                            w_redir_target = br_is_jr ? jr_data : br_target;
                            w_redir_lane   = br_lane;
                        end
                    end else if (!stall && fetch_req && fetch_ready) begin
                        w_pc_nxt = r_pc + C_FETCH_INC;
                    end
                end
                ST_PEND: begin
                    // New br_req is ignored here: only one branch outstanding.
                    if (!stall) begin
                        if (r_pend_is_jr && !jr_data_ok) begin
                            w_state_nxt = ST_JRWAIT;
                        end else begin
                            w_redir        = 1'b1;
                            w_redir_target = r_pend_is_jr ? jr_data : r_pend_target;
                            w_redir_lane   = r_pend_lane;
                        end
                    end
                end
                ST_JRWAIT: begin
                    if (jr_data_ok) begin
                        w_redir        = 1'b1;
                        w_redir_target = jr_data;
                        w_redir_lane   = r_pend_lane;
                    end
                end
                default: begin
                    w_state_nxt = ST_RUN;
                end
            endcase

            if (w_redir) begin
                // Lane 0 branch: delay slot is still in ID, whole IF pair is
                // wrong-path. Lane 1 branch: IF lane 0 is the delay slot.
                w_state_nxt       = ST_RUN;
                w_pc_nxt          = w_redir_target;
                w_flush_nxt       = !w_redir_lane;
                w_kill_nxt        = w_redir_lane;
                w_aerr_nxt        = |w_redir_target[1:0];
                w_pend_target_nxt = 32'd0;
                w_pend_lane_nxt   = 1'b0;
                w_pend_is_jr_nxt  = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state       <= ST_RUN;
            r_pc          <= RESET_PC;
            r_pend_target <= 32'd0;
            r_pend_lane   <= 1'b0;
            r_pend_is_jr  <= 1'b0;
            r_started     <= 1'b0;
            r_flush       <= 1'b0;
            r_kill        <= 1'b0;
            r_aerr        <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_pc          <= w_pc_nxt;
            r_pend_target <= w_pend_target_nxt;
            r_pend_lane   <= w_pend_lane_nxt;
            r_pend_is_jr  <= w_pend_is_jr_nxt;
            r_started     <= 1'b1;
            r_flush       <= w_flush_nxt;
            r_kill        <= w_kill_nxt;
            r_aerr        <= w_aerr_nxt;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fetch_redirect_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fetch_redirect_ctrl
//  Purpose  : Self-checking bench for fetch_redirect_ctrl: directed vector
//             table, hand-written corner sequences, and randomized stimulus
//             against a behavioural reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_redirect_ctrl;

    localparam logic [31:0] C_RESET_PC = 32'hBFC0_0000;

    logic        clk;
    logic        reset;
    logic        stall, exc_req, br_req, br_lane, br_is_jr, jr_data_ok, fetch_ready;
    logic [31:0] exc_pc, br_target, jr_data;
    logic        fetch_req, flush_if, kill_hi, addr_err;
    logic [31:0] fetch_addr;
    logic [1:0]  state_o;

    int total = 0;
    int bad   = 0;

    fetch_redirect_ctrl #(.RESET_PC(C_RESET_PC), .FETCH_BYTES(8)) dut (
        .clk(clk), .reset(reset), .stall(stall),
        .exc_req(exc_req), .exc_pc(exc_pc),
        .br_req(br_req), .br_lane(br_lane), .br_target(br_target),
        .br_is_jr(br_is_jr), .jr_data_ok(jr_data_ok), .jr_data(jr_data),
        .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_ready(fetch_ready),
        .flush_if(flush_if), .kill_hi(kill_hi), .addr_err(addr_err),
        .state_o(state_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        stall, exc, br, lane, jr, jrok, ready;
        logic [31:0] epc, tgt, jrd;
        logic        e_req, e_flush, e_kill, e_aerr;
        logic [31:0] e_addr;
        logic [1:0]  e_state;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic s, logic e, logic [31:0] epc, logic b, logic l,
                                logic [31:0] t, logic j, logic jo, logic [31:0] jd,
                                logic r, logic q, logic [31:0] a, logic f, logic k,
                                logic ae, logic [1:0] st);
        vec_t v;
        v.stall = s; v.exc = e; v.epc = epc; v.br = b; v.lane = l; v.tgt = t;
        v.jr = j; v.jrok = jo; v.jrd = jd; v.ready = r;
        v.e_req = q; v.e_addr = a; v.e_flush = f; v.e_kill = k; v.e_aerr = ae;
        v.e_state = st;
        return v;
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_all(string tag, logic q, logic [31:0] a, logic f, logic k,
                             logic ae, logic [1:0] st);
        check({tag, ".fetch_req"},  32'(fetch_req),  32'(q));
        check({tag, ".fetch_addr"}, fetch_addr,      a);
        check({tag, ".flush_if"},   32'(flush_if),   32'(f));
        check({tag, ".kill_hi"},    32'(kill_hi),    32'(k));
        check({tag, ".addr_err"},   32'(addr_err),   32'(ae));
        check({tag, ".state"},      32'(state_o),    32'(st));
    endtask

    task automatic idle_inputs();
        stall = 0; exc_req = 0; exc_pc = 0; br_req = 0; br_lane = 0; br_target = 0;
        br_is_jr = 0; jr_data_ok = 0; jr_data = 0; fetch_ready = 1;
    endtask

    task automatic apply(vec_t v);
        stall = v.stall; exc_req = v.exc; exc_pc = v.epc; br_req = v.br;
        br_lane = v.lane; br_target = v.tgt; br_is_jr = v.jr; jr_data_ok = v.jrok;
        jr_data = v.jrd; fetch_ready = v.ready;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reset is asserted and released between edges; released before the
    // next edge so that edge is the first one after deassertion.
    task automatic do_reset();
        idle_inputs();
        @(negedge clk);
        reset = 0;
        @(posedge clk);
        #1;
        check_all("reset", 1'b0, C_RESET_PC, 1'b0, 1'b0, 1'b0, 2'd0);
        @(negedge clk);
        reset = 1;
    endtask

    // ---------------- behavioural reference model ----------------
    bit          m_started, m_have_pend, m_wait;
    logic [31:0] m_pc, m_pend_tgt;
    bit          m_pend_lane, m_pend_jr;
    bit          m_flush, m_kill, m_aerr;

    function automatic void m_reset();
        m_started = 0; m_have_pend = 0; m_wait = 0; m_pc = C_RESET_PC;
        m_pend_tgt = 0; m_pend_lane = 0; m_pend_jr = 0;
        m_flush = 0; m_kill = 0; m_aerr = 0;
    endfunction

    function automatic bit m_req();
        return m_started && !m_wait;
    endfunction

    function automatic void m_take(logic [31:0] t, bit lane);
        m_pc = t;
        m_flush = !lane;
        m_kill = lane;
        m_aerr = (t % 4) != 0;
        m_have_pend = 0;
        m_wait = 0;
    endfunction

    // One clock edge worth of behaviour, using the inputs now on the pins.
    function automatic void m_edge();
        bit req_now;
        req_now = m_req();
        m_flush = 0; m_kill = 0; m_aerr = 0;
        if (exc_req) begin
            m_pc = exc_pc; m_flush = 1; m_aerr = (exc_pc % 4) != 0;
            m_have_pend = 0; m_wait = 0;
        end else if (m_wait) begin
            if (jr_data_ok) m_take(jr_data, m_pend_lane);
        end else if (m_have_pend) begin
            if (!stall) begin
                if (m_pend_jr && !jr_data_ok) begin
                    m_have_pend = 0; m_wait = 1;
                end else begin
                    m_take(m_pend_jr ? jr_data : m_pend_tgt, m_pend_lane);
                end
            end
        end else if (br_req) begin
            if (stall) begin
                m_have_pend = 1; m_pend_tgt = br_target; m_pend_lane = br_lane;
                m_pend_jr = br_is_jr;
            end else if (br_is_jr && !jr_data_ok) begin
                m_wait = 1; m_pend_lane = br_lane;
            end else begin
                m_take(br_is_jr ? jr_data : br_target, br_lane);
            end
        end else if (!stall && req_now && fetch_ready) begin
            m_pc = m_pc + 32'd8;
        end
        m_started = 1;
    endfunction

    function automatic logic [1:0] m_state();
        return m_wait ? 2'd2 : (m_have_pend ? 2'd1 : 2'd0);
    endfunction

    // ---------------- test ----------------
    initial begin
        reset = 1;
        idle_inputs();
        #2;

        //        s  e  epc           b  l  tgt           j  jo jd            r   q  addr          f  k  ae st
        vecs.push_back(mk(0,0,0,            0,0,0,            0,0,0,            1,  1,32'hBFC00000,0,0,0,0));
        vecs.push_back(mk(0,0,0,            0,0,0,            0,0,0,            1,  1,32'hBFC00008,0,0,0,0));
        vecs.push_back(mk(0,0,0,            0,0,0,            0,0,0,            1,  1,32'hBFC00010,0,0,0,0));
        vecs.push_back(mk(0,0,0,            1,0,32'hBFC00100, 0,0,0,            1,  1,32'hBFC00100,1,0,0,0));
        vecs.push_back(mk(0,0,0,            0,0,0,            0,0,0,            1,  1,32'hBFC00108,0,0,0,0));
        vecs.push_back(mk(0,0,0,            1,1,32'hBFC00200, 0,0,0,            1,  1,32'hBFC00200,0,1,0,0));
        vecs.push_back(mk(0,0,0,            0,0,0,            0,0,0,            1,  1,32'hBFC00208,0,0,0,0));
        vecs.push_back(mk(0,0,0,            0,0,0,            0,0,0,            0,  1,32'hBFC00208,0,0,0,0));
        vecs.push_back(mk(1,0,0,            1,0,32'hBFC00300, 0,0,0,            1,  1,32'hBFC00208,0,0,0,1));
        vecs.push_back(mk(1,0,0,            0,0,0,            0,0,0,            1,  1,32'hBFC00208,0,0,0,1));
        vecs.push_back(mk(0,0,0,            0,0,0,            0,0,0,            1,  1,32'hBFC00300,1,0,0,0));
        vecs.push_back(mk(0,0,0,            0,0,0,            0,0,0,            1,  1,32'hBFC00308,0,0,0,0));
        vecs.push_back(mk(0,1,32'hBFC00380, 1,1,32'h11110000, 0,0,0,            1,  1,32'hBFC00380,1,0,0,0));
        vecs.push_back(mk(0,0,0,            0,0,0,            0,0,0,            1,  1,32'hBFC00388,0,0,0,0));
        vecs.push_back(mk(0,0,0,            1,0,32'hBFC00402, 0,0,0,            1,  1,32'hBFC00402,1,0,1,0));
        vecs.push_back(mk(0,0,0,            0,0,0,            0,0,0,            1,  1,32'hBFC0040A,0,0,0,0));
        vecs.push_back(mk(0,0,0,            1,1,0,            1,0,0,            1,  0,32'hBFC0040A,0,0,0,2));
        vecs.push_back(mk(0,0,0,            0,0,0,            0,0,0,            1,  0,32'hBFC0040A,0,0,0,2));
        vecs.push_back(mk(0,0,0,            0,0,0,            0,0,0,            1,  0,32'hBFC0040A,0,0,0,2));
        vecs.push_back(mk(0,0,0,            0,0,0,            0,1,32'h80001000, 1,  1,32'h80001000,0,1,0,0));
        vecs.push_back(mk(0,0,0,            0,0,0,            0,0,0,            1,  1,32'h80001008,0,0,0,0));
        vecs.push_back(mk(0,0,0,            1,0,0,            1,1,32'h80002000, 1,  1,32'h80002000,1,0,0,0));
        vecs.push_back(mk(0,0,0,            1,0,0,            1,0,0,            1,  0,32'h80002000,0,0,0,2));
        vecs.push_back(mk(0,1,32'hBFC00380, 0,0,0,            0,0,0,            1,  1,32'hBFC00380,1,0,0,0));
        vecs.push_back(mk(1,0,0,            1,0,32'h00001000, 0,0,0,            1,  1,32'hBFC00380,0,0,0,1));
        vecs.push_back(mk(1,1,32'hBFC00400, 0,0,0,            0,0,0,            1,  1,32'hBFC00400,1,0,0,0));
        vecs.push_back(mk(0,0,0,            0,0,0,            0,0,0,            1,  1,32'hBFC00408,0,0,0,0));
        vecs.push_back(mk(0,0,0,            1,0,32'hFFFFFFF8, 0,0,0,            1,  1,32'hFFFFFFF8,1,0,0,0));
        vecs.push_back(mk(0,0,0,            0,0,0,            0,0,0,            1,  1,32'h00000000,0,0,0,0));

        do_reset();
        for (int i = 0; i < vecs.size(); i++) begin
            apply(vecs[i]);
            tick();
            check_all($sformatf("vec%0d", i), vecs[i].e_req, vecs[i].e_addr,
                      vecs[i].e_flush, vecs[i].e_kill, vecs[i].e_aerr, vecs[i].e_state);
        end

        // JR arriving during stall: PEND, then stall drops before the register
        // is ready -> JRWAIT, then redirect with the latched lane.
        idle_inputs();
        stall = 1; br_req = 1; br_is_jr = 1; br_lane = 1; br_target = 32'hDEAD0000;
        tick();
        check_all("jrpend.a", 1'b1, 32'h00000000, 1'b0, 1'b0, 1'b0, 2'd1);
        idle_inputs();
        tick();
        check_all("jrpend.b", 1'b0, 32'h00000000, 1'b0, 1'b0, 1'b0, 2'd2);
        jr_data_ok = 1; jr_data = 32'h80004001;
        tick();
        check_all("jrpend.c", 1'b1, 32'h80004001, 1'b0, 1'b1, 1'b1, 2'd0);
        idle_inputs();

        // Asynchronous reset asserted mid-cycle takes effect without an edge.
        tick();
        #2;
        reset = 0;
        #1;
        check_all("async_rst", 1'b0, C_RESET_PC, 1'b0, 1'b0, 1'b0, 2'd0);
        @(negedge clk);
        reset = 1;

        // Randomized run against the reference model.
        do_reset();
        m_reset();
        for (int c = 0; c < 3000; c++) begin
            stall       = ($urandom_range(3) == 0);
            exc_req     = ($urandom_range(39) == 0);
            exc_pc      = {$urandom_range(32'hFFFF), 12'h0, 4'($urandom_range(15) == 0 ? 2 : 0)};
            br_req      = ($urandom_range(5) == 0);
            br_lane     = 1'($urandom_range(1));
            br_target   = $urandom & ($urandom_range(7) == 0 ? 32'hFFFF_FFFF : 32'hFFFF_FFF8);
            br_is_jr    = ($urandom_range(2) == 0);
            jr_data_ok  = ($urandom_range(2) == 0);
            jr_data     = $urandom & ($urandom_range(7) == 0 ? 32'hFFFF_FFFF : 32'hFFFF_FFF8);
            fetch_ready = ($urandom_range(3) != 0);
            m_edge();
            tick();
            check_all("rand", 1'(m_req()), m_pc, 1'(m_flush), 1'(m_kill),
                      1'(m_aerr), m_state());
            if (flush_if && kill_hi) check("rand.exclusive", 32'd1, 32'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
